// File: rtl/pipeif_fetch_if.sv
// Instruction-memory request/ready channel between the fetch stage (master) and instruction memory (slave).
interface pipeif_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory, and loads the IF/ID register.
// Redirects from ID take effect with one delay slot; a fetch blocked by a stall waits in a skid register.
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          stall,
    input  logic [1:0]    pcsource,
    input  logic [31:0]   bpc,
    input  logic [31:0]   rpc,
    input  logic [31:0]   jpc,
    pipeif_fetch_if.master imem,
    output logic [31:0]   pc,
    output logic          dvalid,
    output logic [31:0]   dinst,
    output logic [31:0]   dpc4
);
    localparam int unsigned XLEN = 32;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] FULL = 2'b10;

    logic [1:0]      state, state_n;
    logic            req_q, req_n;
    logic [XLEN-1:0] pc_n, dinst_n, dpc4_n, rtgt, rtgt_n, sk_inst, sk_inst_n, sk_pc4, sk_pc4_n;
    logic            dvalid_n, rpend, rpend_n;

    logic            done, consume, redir;
    logic [XLEN-1:0] pc4, tgt;

    assign done    = req_q & imem.ready;
    assign consume = ~stall | ~dvalid;
    assign redir   = dvalid & ~stall & (pcsource != 2'b00);
    assign pc4     = pc + XLEN'(4);

    always_comb begin
        tgt = pc4;
        case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = rpc;
            2'b11:   tgt = jpc;
            default: tgt = pc4;
        endcase
    end

    // Next-state and next-register logic; everything holds unless a case below updates it.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        dvalid_n  = dvalid;
        dinst_n   = dinst;
        dpc4_n    = dpc4;
        rpend_n   = rpend;
        rtgt_n    = rtgt;
        sk_inst_n = sk_inst;
        sk_pc4_n  = sk_pc4;

        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (done) begin
                    // Newest redirect wins over a pending one.
                    pc_n    = redir ? tgt : (rpend ? rtgt : pc4);
                    rpend_n = 1'b0;
                    if (consume) begin
                        dinst_n  = imem.rdata;
                        dpc4_n   = pc4;
                        dvalid_n = 1'b1;
                    end else begin
                        sk_inst_n = imem.rdata;
                        sk_pc4_n  = pc4;
                        state_n   = FULL;
                    end
                end else begin
                    if (redir) begin
                        rtgt_n  = tgt;
                        rpend_n = 1'b1;
                    end
                    if (consume) begin
                        dvalid_n = 1'b0;
                        dinst_n  = '0;
                    end
                end
            end
            FULL: begin
                if (!stall) begin
                    dinst_n  = sk_inst;
                    dpc4_n   = sk_pc4;
                    dvalid_n = 1'b1;
                    state_n  = REQ;
                    if (redir) pc_n = tgt;
                end
            end
            default: state_n = IDLE;
        endcase

        req_n = (state_n == REQ);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            pc      <= RESET_PC;
            dvalid  <= 1'b0;
            dinst   <= '0;
            dpc4    <= '0;
            rpend   <= 1'b0;
            rtgt    <= '0;
            sk_inst <= '0;
            sk_pc4  <= '0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            pc      <= pc_n;
            dvalid  <= dvalid_n;
            dinst   <= dinst_n;
            dpc4    <= dpc4_n;
            rpend   <= rpend_n;
            rtgt    <= rtgt_n;
            sk_inst <= sk_inst_n;
            sk_pc4  <= sk_pc4_n;
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = pc;
endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed vector bench for pipeif_fetch: table of per-cycle inputs and hand-computed post-edge outputs,
// plus hand-written reset sequences.
module tb_pipeif_fetch;
    logic        clock = 1'b0;
    logic        resetn;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] pc, dinst, dpc4;
    logic        dvalid;

    int checks = 0;
    int errors = 0;

    pipeif_fetch_if imem_bus();

    pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .resetn(resetn), .stall(stall), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem(imem_bus),
        .pc(pc), .dvalid(dvalid), .dinst(dinst), .dpc4(dpc4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic [1:0]  ps;
        logic [31:0] tgt;
        logic        ready;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_dinst;
        logic [31:0] e_dpc4;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic [1:0] ps, input logic [31:0] tgt, input logic rdy,
                       input logic [31:0] rd, input logic er, input logic [31:0] ea, input logic edv,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v = '{s, ps, tgt, rdy, rd, er, ea, edv, ei, ep};
        vecs.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"},    32'(imem_bus.req), 32'h0);
        chk({tag, "_pc"},     pc,               32'h0);
        chk({tag, "_dvalid"}, 32'(dvalid),      32'h0);
        chk({tag, "_dinst"},  dinst,            32'h0);
        chk({tag, "_dpc4"},   dpc4,             32'h0);
    endtask

    // Release reset between edges: no request in the first cycle, request at RESET_PC in the second.
    task automatic release_reset(input string tag);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk({tag, "_cyc1_req"}, 32'(imem_bus.req), 32'h0);
        @(posedge clock); #1;
        chk({tag, "_cyc2_req"},  32'(imem_bus.req), 32'h1);
        chk({tag, "_cyc2_addr"}, imem_bus.addr,     32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        stall = 1'b0; pcsource = 2'b00;
        bpc = '0; rpc = '0; jpc = '0;
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 32'hFFFF_0000;

        //   stall ps     tgt           rdy rdata         req addr          dv dinst         dpc4
        add(0, 2'b00, 32'h0,        1, 32'h11,        1, 32'h4,         1, 32'h11,        32'h4);
        add(0, 2'b00, 32'h0,        1, 32'h22,        1, 32'h8,         1, 32'h22,        32'h8);
        add(0, 2'b00, 32'h0,        1, 32'h33,        1, 32'hC,         1, 32'h33,        32'hC);
        add(1, 2'b00, 32'h0,        1, 32'h44,        0, 32'h10,        1, 32'h33,        32'hC);
        add(1, 2'b00, 32'h0,        1, 32'hBAD1,      0, 32'h10,        1, 32'h33,        32'hC);
        add(0, 2'b00, 32'h0,        0, 32'hBAD2,      1, 32'h10,        1, 32'h44,        32'h10);
        add(0, 2'b01, 32'h40,       1, 32'h55,        1, 32'h40,        1, 32'h55,        32'h14);
        add(0, 2'b00, 32'h0,        0, 32'hBAD3,      1, 32'h40,        0, 32'h0,         32'h14);
        add(0, 2'b00, 32'h0,        1, 32'h66,        1, 32'h44,        1, 32'h66,        32'h44);
        add(0, 2'b10, 32'h200,      0, 32'hBAD4,      1, 32'h44,        0, 32'h0,         32'h44);
        add(0, 2'b10, 32'h999,      0, 32'hBAD5,      1, 32'h44,        0, 32'h0,         32'h44);
        add(0, 2'b00, 32'h0,        0, 32'hBAD6,      1, 32'h44,        0, 32'h0,         32'h44);
        add(0, 2'b00, 32'h0,        1, 32'h77,        1, 32'h200,       1, 32'h77,        32'h48);
        add(0, 2'b00, 32'h0,        1, 32'h88,        1, 32'h204,       1, 32'h88,        32'h204);
        add(0, 2'b00, 32'h0,        0, 32'hBAD7,      1, 32'h204,       0, 32'h0,         32'h204);
        add(1, 2'b00, 32'h0,        1, 32'h99,        1, 32'h208,       1, 32'h99,        32'h208);
        add(1, 2'b00, 32'h0,        1, 32'hAA,        0, 32'h20C,       1, 32'h99,        32'h208);
        add(0, 2'b11, 32'h300,      0, 32'hBAD8,      1, 32'h300,       1, 32'hAA,        32'h20C);
        add(0, 2'b00, 32'h0,        1, 32'hBB,        1, 32'h304,       1, 32'hBB,        32'h304);
        add(0, 2'b01, 32'hFFFF_FFFC, 1, 32'hCC,       1, 32'hFFFF_FFFC, 1, 32'hCC,        32'h308);
        add(0, 2'b00, 32'h0,        1, 32'hDD,        1, 32'h0,         1, 32'hDD,        32'h0);
        add(0, 2'b11, 32'h500,      0, 32'hBAD9,      1, 32'h0,         0, 32'h0,         32'h0);
        add(0, 2'b00, 32'h0,        1, 32'hEE,        1, 32'h500,       1, 32'hEE,        32'h4);

        // Reset held with memory claiming ready.
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("rst");
        release_reset("rel");

        foreach (vecs[i]) begin
            stall          = vecs[i].stall;
            pcsource       = vecs[i].ps;
            bpc            = (vecs[i].ps == 2'b01) ? vecs[i].tgt : 32'hB0B0_0000;
            rpc            = (vecs[i].ps == 2'b10) ? vecs[i].tgt : 32'hC0C0_0000;
            jpc            = (vecs[i].ps == 2'b11) ? vecs[i].tgt : 32'hD0D0_0000;
            imem_bus.ready = vecs[i].ready;
            imem_bus.rdata = vecs[i].rdata;
            @(posedge clock); #1;
            chk($sformatf("v%0d_req", i),    32'(imem_bus.req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i),   imem_bus.addr,     vecs[i].e_addr);
            chk($sformatf("v%0d_pc", i),     pc,                vecs[i].e_addr);
            chk($sformatf("v%0d_dvalid", i), 32'(dvalid),       32'(vecs[i].e_dv));
            chk($sformatf("v%0d_dinst", i),  dinst,             vecs[i].e_dinst);
            chk($sformatf("v%0d_dpc4", i),   dpc4,              vecs[i].e_dpc4);
        end

        // Reset mid-request: request is up at 0x500; drop resetn between edges.
        stall = 1'b0; pcsource = 2'b00;
        imem_bus.ready = 1'b0;
        chk("mid_pre_req", 32'(imem_bus.req), 32'h1);
        #2;
        resetn = 1'b0;
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 32'hBADA;
        #1;
        check_reset_state("mid_async");
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("mid_hold");
        release_reset("mid_rel");
        imem_bus.rdata = 32'h1234;
        @(posedge clock); #1;
        chk("post_dinst", dinst, 32'h1234);
        chk("post_dpc4",  dpc4,  32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeif_fetch.md
# pipeif_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the PC and the next-PC multiplexer, runs a request/ready handshake to instruction memory, and loads the IF/ID pipeline register consumed by the ID-stage control unit. It honours the ID load-use stall and applies ID branch/jump redirects with exactly one delay slot. The instruction after a branch is always delivered; cancelling it is ID's job.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  1  ID load-use stall (LOADDEPEN); 1 = ID holds its instruction.
- pcsource  in  2  from ID: 00 PC+4, 01 branch target, 10 register target (jr), 11 jump target.
- bpc  in  32  branch target computed in ID.
- rpc  in  32  register-sourced target (forwarded rs).
- jpc  in  32  jump target {dpc4[31:28], addr, 2'b00}.
- imem_ready  in  1  instruction memory: rdata valid, request accepted this cycle.
- imem_rdata  in  32  fetched instruction word.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equals pc.
- pc  out  32  current fetch PC.
- dvalid  out  1  IF/ID register holds a real instruction.
- dinst  out  32  IF/ID instruction; 32'h0 when dvalid=0.
- dpc4  out  32  IF/ID PC+4 of dinst.

## Operation
- Definitions:
  - done = imem_req & imem_ready.
  - consume = ~stall | ~dvalid.
  - redir = dvalid & ~stall & (pcsource != 00).
  - tgt = pcsource mux of {bpc, rpc, jpc}.
- FSM states:
  - IDLE: reset state, imem_req=0; unconditionally goes to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc.
  - FULL: imem_req=0; a completed fetch waits in the skid register (sk_inst, sk_pc4).
- REQ, done & consume: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1; stay in REQ.
- REQ, done & ~consume: sk_inst<=imem_rdata, sk_pc4<=pc+4; go to FULL.
- PC update on done: pc <= redir ? tgt : rpend ? rtgt : pc+4; rpend<=0.
- Redirect while a request is outstanding (REQ & ~done & redir): rtgt<=tgt, rpend<=1; pc and imem_addr are not changed.
- REQ, ~done & consume: dvalid<=0, dinst<=0 (bubble).
- FULL & ~stall:
  - IF/ID <= skid, dvalid<=1; go to REQ.
  - If redir, pc<=tgt.
- FULL & stall: hold all state.
- rpend and redir are never both applied. redir takes priority, because the newest redirect belongs to the instruction now leaving ID.
- pc+4 and all target arithmetic are 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (asynchronous, resetn=0):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - dvalid=0, dinst=0, dpc4=0.
  - rpend=0, rtgt=0, skid=0.
- First request is issued in the second cycle after resetn rises.
- Zero-wait memory: one instruction per cycle. Fetch-to-dvalid latency is 1 cycle (registered at the done edge).
- imem_addr and imem_req are stable while imem_req=1 and imem_ready=0. Memory may hold ready low for any number of cycles.
- Delay slot: the fetch in flight when ID redirects, or the one already in the skid register, is delivered. The next request address is tgt.
- stall with dvalid=0 is ignored; a bubble never blocks fetch.
- Reset mid-request drops imem_req asynchronously. A late imem_ready is ignored.

## Test plan
- Reset: hold resetn=0 with imem_ready=1 -> imem_req=0, pc=0, dvalid=0; release -> cycle 1 imem_req=0, cycle 2 imem_req=1 with imem_addr=0.
- Straight line, ready=1, rdata=0x11,0x22,0x33 -> dinst 0x11/0x22/0x33 on consecutive cycles, dpc4=4/8/12, imem_addr 0,4,8,12.
- Stall at completion: stall=1 while fetch of 0x8 completes -> state FULL, imem_req=0, dinst unchanged, pc=0xC; stall=0 -> dinst=skid word, dpc4=0xC, next cycle imem_req=1 with imem_addr=0xC.
- Branch, zero wait: dinst at 0x8 with pcsource=01, bpc=0x40, fetch of 0xC completes the same cycle -> next dinst is the 0xC word, next imem_addr=0x40.
- Redirect under wait states: ready held low 3 cycles at addr 0x10; jr with rpc=0x200 consumed in cycle 1 -> imem_addr stays 0x10 until done, then 0x200; rpend clears.
- Reset mid-request: resetn=0 while imem_req=1 at 0x24 -> imem_req=0 immediately, pc=RESET_PC, dvalid=0.
